// File: rtl/vga_frame_adapter.sv
// vga_frame_adapter: frame-buffered 640x480@60Hz VGA output.
// Single-pixel writes land in an on-chip frame buffer. The buffer is scanned
// out continuously, and each stored pixel is upscaled to a 4x4 block
// (160x120 buffer) or a 2x2 block (320x240 buffer).
// Ports:
//   clock, reset_n          50 MHz system clock, async active-low reset
//   colour, x, y, plot      write port; writes with out-of-range x/y are dropped
//   VGA_R/G/B               10-bit DAC values, forced to 0 while blanking
//   VGA_HS, VGA_VS          active-low syncs
//   VGA_BLANK               high in the visible region
//   VGA_SYNC                tied high
//   VGA_CLK                 25 MHz pixel clock (clock/2)
module vga_frame_adapter #(
  parameter string       RESOLUTION              = "160x120",
  parameter string       MONOCHROME              = "FALSE",
  parameter int unsigned BITS_PER_COLOUR_CHANNEL = 1,
  parameter string       BACKGROUND_IMAGE        = "black.mif",
  localparam bit          HI_RES = (RESOLUTION == "320x240"),
  localparam bit          MONO   = (MONOCHROME == "TRUE"),
  localparam int unsigned CW     = MONO ? 1 : 3 * BITS_PER_COLOUR_CHANNEL,
  localparam int unsigned XW     = HI_RES ? 9 : 8,
  localparam int unsigned YW     = HI_RES ? 8 : 7
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [CW-1:0] colour,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic          plot,
  output logic [9:0]    VGA_R,
  output logic [9:0]    VGA_G,
  output logic [9:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic          VGA_SYNC,
  output logic          VGA_CLK
);

  localparam int unsigned FB_W     = HI_RES ? 320 : 160;
  localparam int unsigned FB_H     = HI_RES ? 240 : 120;
  localparam int unsigned DEPTH    = FB_W * FB_H;
  localparam int unsigned AW       = HI_RES ? 17 : 15;
  // y*W as two shifted copies of y: W = 2^SH_A + 2^SH_B
  localparam int unsigned SH_A     = HI_RES ? 8 : 7;
  localparam int unsigned SH_B     = HI_RES ? 6 : 5;
  localparam int unsigned SCALE_SH = HI_RES ? 1 : 2;
  localparam int unsigned N        = MONO ? 1 : BITS_PER_COLOUR_CHANNEL;
  localparam int unsigned REP      = 10 / N + 1;
  localparam int unsigned CNT_W    = 10;

  localparam int unsigned H_VIS        = 640;
  localparam int unsigned H_SYNC_FIRST = 656;
  localparam int unsigned H_SYNC_LAST  = 751;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_VIS        = 480;
  localparam int unsigned V_SYNC_FIRST = 490;
  localparam int unsigned V_SYNC_LAST  = 491;
  localparam int unsigned V_TOTAL      = 525;

  // Elaboration-time guard on configuration values
  if (!(RESOLUTION == "160x120" || RESOLUTION == "320x240") ||
      !(MONOCHROME == "TRUE" || MONOCHROME == "FALSE") ||
      BITS_PER_COLOUR_CHANNEL < 1 || BITS_PER_COLOUR_CHANNEL > 3 ||
      BACKGROUND_IMAGE == "") begin : g_bad_params
    $error("vga_frame_adapter: illegal parameter value");
  end

  // Linear frame-buffer address of (col,row)
  function automatic logic [AW-1:0] fb_addr(input logic [YW-1:0] row,
                                            input logic [XW-1:0] col);
    return (AW'(row) << SH_A) + (AW'(row) << SH_B) + AW'(col);
  endfunction

  // Replicate an N-bit channel MSB-first across 10 bits
  function automatic logic [9:0] expand(input logic [N-1:0] ch);
    logic [REP*N-1:0] rep;
    rep = {REP{ch}};
    return rep[REP*N-1 -: 10];
  endfunction

  logic [CW-1:0]    fb [DEPTH];
  logic             wr_en_c;
  logic [AW-1:0]    wr_addr_c;

  logic [CNT_W-1:0] hcount, vcount;
  logic             pix_tick_c;
  logic             visible_c, hs_n_c, vs_n_c;
  logic [AW-1:0]    rd_addr_c, rd_addr;
  logic             hs_d, vs_d, blank_d;
  logic [CW-1:0]    rd_data_c;
  logic [N-1:0]     r_c, g_c, b_c;

  assign VGA_SYNC = 1'b1;

  // Write port: in-range strobes only, ignored while in reset
  assign wr_en_c   = plot && (x < XW'(FB_W)) && (y < YW'(FB_H));
  assign wr_addr_c = fb_addr(y, x);

  always_ff @(posedge clock) begin
    if (reset_n && wr_en_c) fb[wr_addr_c] <= colour;
  end

  // The pixel advances on the clock edge that raises VGA_CLK
  assign pix_tick_c = ~VGA_CLK;

  // Timing decode and read address for the current scan position
  always_comb begin
    visible_c = (hcount < CNT_W'(H_VIS)) && (vcount < CNT_W'(V_VIS));
    hs_n_c    = !((hcount >= CNT_W'(H_SYNC_FIRST)) && (hcount <= CNT_W'(H_SYNC_LAST)));
    vs_n_c    = !((vcount >= CNT_W'(V_SYNC_FIRST)) && (vcount <= CNT_W'(V_SYNC_LAST)));
    rd_addr_c = '0;
    if (visible_c) begin
      rd_addr_c = fb_addr(YW'(vcount >> SCALE_SH), XW'(hcount >> SCALE_SH));
    end
  end

  // Pixel divider, scan counters and first pipeline stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      VGA_CLK <= 1'b0;
      hcount  <= '0;
      vcount  <= '0;
      rd_addr <= '0;
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      blank_d <= 1'b0;
    end else begin
      VGA_CLK <= ~VGA_CLK;
      if (pix_tick_c) begin
        rd_addr <= rd_addr_c;
        hs_d    <= hs_n_c;
        vs_d    <= vs_n_c;
        blank_d <= visible_c;
        if (hcount == CNT_W'(H_TOTAL - 1)) begin
          hcount <= '0;
          vcount <= (vcount == CNT_W'(V_TOTAL - 1)) ? '0 : vcount + CNT_W'(1);
        end else begin
          hcount <= hcount + CNT_W'(1);
        end
      end
    end
  end

  // RAM read data split into channels
  assign rd_data_c = fb[rd_addr];

  if (MONO) begin : g_mono
    assign r_c = rd_data_c;
    assign g_c = rd_data_c;
    assign b_c = rd_data_c;
  end else begin : g_rgb
    assign r_c = rd_data_c[3*N-1 -: N];
    assign g_c = rd_data_c[2*N-1 -: N];
    assign b_c = rd_data_c[N-1:0];
  end

  // Second stage: registered RAM data plus the matching delayed syncs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else if (pix_tick_c) begin
      VGA_HS    <= hs_d;
      VGA_VS    <= vs_d;
      VGA_BLANK <= blank_d;
      VGA_R     <= blank_d ? expand(r_c) : '0;
      VGA_G     <= blank_d ? expand(g_c) : '0;
      VGA_B     <= blank_d ? expand(b_c) : '0;
    end
  end

endmodule

// File: tb/tb_vga_frame_adapter.sv
// Testbench for vga_frame_adapter (160x120, 3-bit colour).
// Expected outputs come from a pixel-index model: after the e-th clock edge
// since reset release the outputs show scan pixel e/2-1, whose syncs, blank
// and colour are computed from the frame-buffer contents tracked here.
module tb_vga_frame_adapter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] colour;
  logic [7:0] x;
  logic [6:0] y;
  logic       plot;
  logic [9:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

  vga_frame_adapter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .colour   (colour),
    .x        (x),
    .y        (y),
    .plot     (plot),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B),
    .VGA_HS   (VGA_HS),
    .VGA_VS   (VGA_VS),
    .VGA_BLANK(VGA_BLANK),
    .VGA_SYNC (VGA_SYNC),
    .VGA_CLK  (VGA_CLK)
  );

  always #10 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  int         ecnt;
  bit         cmp_en  = 1'b0;
  bit         rgb_chk = 1'b0;
  logic [2:0] model_mem [19200];
  logic [33:0] act_v, exp_v;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Clock edges since the last reset release
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  function automatic int cur_pix();
    if (ecnt == 0) return -1;
    return (ecnt - 1) / 2 - 1;
  endfunction

  function automatic logic [29:0] chan_expand(input logic [2:0] c);
    return {c[2] ? 10'h3FF : 10'h000, c[1] ? 10'h3FF : 10'h000, c[0] ? 10'h3FF : 10'h000};
  endfunction

  // Expected {VGA_CLK,HS,VS,BLANK,R,G,B} after edge number e (0-based)
  function automatic logic [33:0] expect_out(input int e);
    int p, h, v;
    logic clk_e, hs, vs, bl;
    logic [29:0] rgb;
    clk_e = (e % 2 == 0);
    p = e / 2 - 1;
    if (p < 0) return {clk_e, 1'b1, 1'b1, 1'b0, 30'd0};
    h  = p % 800;
    v  = (p / 800) % 525;
    hs = !(h >= 656 && h < 656 + 96);
    vs = !(v >= 490 && v < 492);
    bl = (h < 640) && (v < 480);
    rgb = bl ? chan_expand(model_mem[(v / 4) * 160 + h / 4]) : 30'd0;
    if (!rgb_chk) rgb = 30'd0;
    return {clk_e, hs, vs, bl, rgb};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      if (!reset_n || ecnt == 0) begin
        act_v = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B};
        check("reset_values", act_v, {1'b0, 1'b1, 1'b1, 1'b0, 30'd0});
      end else begin
        act_v = {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK,
                 rgb_chk ? {VGA_R, VGA_G, VGA_B} : 30'd0};
        exp_v = expect_out(ecnt - 1);
        check("scan", act_v, exp_v);
      end
    end
  end

  // Hand-computed pixels pinning the model
  always @(negedge clock) begin
    if (cmp_en && rgb_chk && reset_n && ecnt > 0) begin
      case (cur_pix())
        1603: check("top_left_block_red", {4'd0, VGA_R, VGA_G, VGA_B}, {4'd0, 10'h3FF, 20'h0});
        1604: check("right_of_block_bg", {4'd0, VGA_R, VGA_G, VGA_B}, 34'd0);
        3200: check("row1_green", {4'd0, VGA_R, VGA_G, VGA_B}, {4'd0, 10'h0, 10'h3FF, 10'h0});
        default: ;
      endcase
    end
  end

  // One write-port cycle; the model follows only writes the design must accept
  task automatic put(input int xv, input int yv, input logic [2:0] cv, input bit en);
    @(negedge clock);
    #1;
    x      = 8'(xv);
    y      = 7'(yv);
    colour = cv;
    plot   = en;
    @(posedge clock);
    if (en && reset_n && xv < 160 && yv < 120) model_mem[yv * 160 + xv] = cv;
  endtask

  // HS period, HS low time and visible time of one line, in clocks
  task automatic measure_line();
    int n, lowc, blkc;
    bit ok;
    logic prev;
    ok = 1'b0;
    prev = VGA_HS;
    for (n = 0; n < 4000; n++) begin
      @(negedge clock);
      if (prev && !VGA_HS) begin
        ok = 1'b1;
        break;
      end
      prev = VGA_HS;
    end
    check("hs_first_fall_seen", 34'(ok), 34'd1);
    lowc = 0;
    blkc = 0;
    ok = 1'b0;
    for (n = 1; n < 4000; n++) begin
      lowc += VGA_HS ? 0 : 1;
      blkc += VGA_BLANK ? 1 : 0;
      prev = VGA_HS;
      @(negedge clock);
      if (prev && !VGA_HS) begin
        ok = 1'b1;
        break;
      end
    end
    check("hs_second_fall_seen", 34'(ok), 34'd1);
    check("hs_period_clocks", 34'(n), 34'd1600);
    check("hs_low_clocks", 34'(lowc), 34'd192);
    check("blank_high_clocks", 34'(blkc), 34'd1280);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] c;
    int yv;
    int k;
    int row;
    reset_n = 1'b0;
    plot    = 1'b0;
    x       = '0;
    y       = '0;
    colour  = '0;
    cmp_en  = 1'b1;
    repeat (5) @(posedge clock);
    check("vga_sync_const", 34'(VGA_SYNC), 34'd1);
    @(negedge clock);
    #5 reset_n = 1'b1;

    // Fill the rows the scan reaches inside this run
    for (int yy = 0; yy <= 10; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        c = 3'($urandom);
        if (yy == 0 && xx == 0) c = 3'b100;
        if (yy == 0 && xx == 1) c = 3'b000;
        if (yy == 1 && xx == 0) c = 3'b010;
        put(xx, yy, c, 1'b1);
      end
    end
    put(159, 119, 3'b111, 1'b1);
    put(160, 0, 3'b111, 1'b1);
    put(200, 3, 3'b111, 1'b1);
    put(5, 120, 3'b111, 1'b1);
    put(255, 127, 3'b111, 1'b1);
    put(0, 0, 3'b000, 1'b0);

    // Writes during reset must be ignored
    @(posedge clock);
    #3 reset_n = 1'b0;
    put(0, 2, ~model_mem[320], 1'b1);
    put(7, 4, ~model_mem[4 * 160 + 7], 1'b1);
    put(0, 0, 3'b000, 1'b0);
    check("ram_bottom_right", 34'(dut.fb[19199]), 34'd7);
    check("ram_oor_untouched", 34'(dut.fb[160]), 34'(3'b010));
    @(negedge clock);
    #5 reset_n = 1'b1;
    rgb_chk = 1'b1;

    // Scan from (0,0) with random writes kept ahead of the beam
    fork
      measure_line();
      begin
        for (int i = 0; i < 70000 && cur_pix() < 36 * 800; i++) begin
          k   = int'($urandom_range(0, 7));
          row = (cur_pix() < 0) ? 0 : cur_pix() / 3200;
          if (k < 2) begin
            put(0, 0, 3'b000, 1'b0);
          end else if (k == 2) begin
            put(int'($urandom_range(160, 255)), int'($urandom_range(0, 127)), 3'($urandom), 1'b1);
          end else if (k == 3) begin
            put(int'($urandom_range(0, 159)), int'($urandom_range(120, 127)), 3'($urandom), 1'b1);
          end else begin
            if (row + 2 <= 10) yv = int'($urandom_range(row + 2, 10));
            else               yv = int'($urandom_range(20, 119));
            put(int'($urandom_range(0, 159)), yv, 3'($urandom), 1'b1);
          end
        end
        put(0, 0, 3'b000, 1'b0);
        check("scan1_reached_line36", 34'(cur_pix() >= 36 * 800), 34'd1);
      end
    join

    // Mid-frame reset, then the scan restarts from (0,0) with contents kept
    @(posedge clock);
    #3 reset_n = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    #5 reset_n = 1'b1;
    for (int i = 0; i < 20000 && cur_pix() < 10 * 800; i++) @(negedge clock);
    check("scan2_reached_line10", 34'(cur_pix() >= 10 * 800), 34'd1);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
